ram_readout_fsm: RTL

Read-side controller for the capture BRAM. Once the capture FSM reports the memory full, this block walks addresses 0..DEPTH-1 and drives BRAM read enable/address. It registers each word and streams it out on a valid/ready interface (e.g. to a UART transmitter). After the last word is accepted it pulses done and a clear-full request that re-arms capture.

---
 rtl/ram_readout_fsm.sv | 107 ++++++++++
 1 files changed

// File: rtl/ram_readout_fsm.sv
// Read-side controller for the capture BRAM. When the memory is full it walks
// every address once and streams each word out on a valid/ready interface.
module ram_readout_fsm #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_mem_full,
  input  logic              i_start,
  output logic              o_read_ena,
  output logic [ADDR_W-1:0] o_read_addr,
  input  logic [DATA_W-1:0] i_read_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_clear_full
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_PRESENT,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                valid_q;
  logic                read_ena_q;
  logic                busy_q;
  logic                done_q;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; the synchronous reset wins over every other input.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      read_ena_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      read_ena_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start && i_mem_full) begin
            state_q    <= S_FETCH;
            addr_q     <= '0;
            read_ena_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_FETCH: begin
          state_q <= S_LATCH;
        end
        S_LATCH: begin
          // BRAM output is valid in this cycle, one cycle after the enable.
          data_q  <= i_read_data;
          valid_q <= 1'b1;
          state_q <= S_PRESENT;
        end
        S_PRESENT: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            if (addr_q == LAST_ADDR) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              addr_q     <= addr_q + 1'b1;
              read_ena_q <= 1'b1;
              state_q    <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          addr_q  <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_read_ena   = read_ena_q;
  assign o_read_addr  = addr_q;
  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_clear_full = done_q;

endmodule
